// File: rtl/led_matrix_scan_driver_pkg.sv
// Shared types and polarity helpers for the 7x5 LED matrix scan driver.
package led_matrix_scan_driver_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    BLANK = 2'd3
  } scan_state_e;

  typedef logic [NUM_ROWS-1:0] col_img_t;
  typedef logic [NUM_COLS-1:0] col_strobe_t;

  // Column strobe with at most one active bit, polarity applied last.
  function automatic col_strobe_t col_strobe(input logic active, input logic [2:0] idx,
                                             input logic active_low);
    col_strobe_t onehot;
    onehot = active ? (col_strobe_t'(1) << idx) : '0;
    return active_low ? ~onehot : onehot;
  endfunction

  function automatic col_img_t row_drive(input logic lit, input col_img_t img,
                                         input logic active_low);
    col_img_t rows;
    rows = lit ? img : '0;
    return active_low ? ~rows : rows;
  endfunction

endpackage

// File: rtl/led_matrix_scan_driver_if.sv
// Controller-to-scan-driver bundle: enables, column images and matrix drive outputs.
interface led_matrix_scan_driver_if;
  import led_matrix_scan_driver_pkg::*;

  logic        enable;
  logic        blink_en;
  col_img_t    col1_in;
  col_img_t    col2_in;
  col_img_t    col3_in;
  col_img_t    col4_in;
  col_img_t    col5_in;
  col_strobe_t col_sel;
  col_img_t    row_out;
  logic        frame_tick;

  modport master (
    output enable, blink_en, col1_in, col2_in, col3_in, col4_in, col5_in,
    input  col_sel, row_out, frame_tick
  );

  modport slave (
    input  enable, blink_en, col1_in, col2_in, col3_in, col4_in, col5_in,
    output col_sel, row_out, frame_tick
  );
endinterface

// File: rtl/led_matrix_scan_driver_scan_dwell_counter.sv
// Loadable down-counter that flags terminal count; times both column dwell and blanking.
module scan_dwell_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // A load of N-1 on state entry gives exactly N cycles before terminal count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/led_matrix_scan_driver.sv
// Column-multiplexed LED matrix driver: frame snapshot, dwell/blank scanning and blink.
module led_matrix_scan_driver
  import led_matrix_scan_driver_pkg::*;
#(
  parameter int DWELL_CYCLES   = 10000,
  parameter int BLANK_CYCLES   = 50,
  parameter int BLINK_FRAMES   = 100,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input logic                     clk,
  input logic                     reset,
  led_matrix_scan_driver_if.slave bus
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       LAST_COL   = 3'(NUM_COLS - 1);

  scan_state_e       state_q, state_d;
  logic [2:0]        col_idx_q, col_idx_d;
  col_img_t          snapshot_q [NUM_COLS];
  col_img_t          snapshot_d [NUM_COLS];
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              frame_tick_q, frame_tick_d;
  col_strobe_t       col_sel_q, col_sel_d;
  col_img_t          row_out_q, row_out_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_value;
  logic              cnt_tc;
  logic              col_done;
  logic              lit;

  scan_dwell_counter #(
    .WIDTH(CNT_W)
  ) u_dwell_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .tc         (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    col_idx_d      = col_idx_q;
    snapshot_d     = snapshot_q;
    frame_cnt_d    = frame_cnt_q;
    blink_phase_d  = blink_phase_q;
    frame_tick_d   = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    col_done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        snapshot_d[0]  = bus.col1_in;
        snapshot_d[1]  = bus.col2_in;
        snapshot_d[2]  = bus.col3_in;
        snapshot_d[3]  = bus.col4_in;
        snapshot_d[4]  = bus.col5_in;
        col_idx_d      = '0;
        state_d        = DWELL;
        cnt_load       = 1'b1;
        cnt_load_value = DWELL_LOAD;
      end
      DWELL: begin
        if (cnt_tc) begin
          if (BLANK_CYCLES > 0) begin
            state_d        = BLANK;
            cnt_load       = 1'b1;
            cnt_load_value = BLANK_LOAD;
          end else begin
            col_done = 1'b1;
          end
        end
      end
      BLANK: begin
        if (cnt_tc) begin
          col_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // End of a column: advance, or close the frame and step the blink timer.
    if (col_done) begin
      if (col_idx_q < LAST_COL) begin
        col_idx_d      = col_idx_q + 3'd1;
        state_d        = DWELL;
        cnt_load       = 1'b1;
        cnt_load_value = DWELL_LOAD;
      end else begin
        state_d      = LOAD;
        frame_tick_d = 1'b1;
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
      end
    end

    // Disable wins over any transition but leaves the blink timer untouched.
    if (!bus.enable) begin
      state_d        = IDLE;
      col_idx_d      = col_idx_q;
      snapshot_d     = snapshot_q;
      frame_cnt_d    = frame_cnt_q;
      blink_phase_d  = blink_phase_q;
      frame_tick_d   = 1'b0;
      cnt_load       = 1'b0;
      cnt_load_value = '0;
    end

    lit       = (state_d == DWELL);
    col_sel_d = col_strobe(lit, col_idx_d, COL_ACTIVE_LOW);
    row_out_d = row_drive(lit && !(bus.blink_en && blink_phase_q),
                          snapshot_d[col_idx_d], ROW_ACTIVE_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      col_idx_q     <= '0;
      snapshot_q    <= '{default: '0};
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      col_sel_q     <= col_strobe(1'b0, 3'd0, COL_ACTIVE_LOW);
      row_out_q     <= row_drive(1'b0, '0, ROW_ACTIVE_LOW);
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      snapshot_q    <= snapshot_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_tick_q  <= frame_tick_d;
      col_sel_q     <= col_sel_d;
      row_out_q     <= row_out_d;
    end
  end

  assign bus.col_sel    = col_sel_q;
  assign bus.row_out    = row_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: doc/led_matrix_scan_driver.md
Name: led_matrix_scan_driver

Overview:
Time-multiplexes the five 7-bit column images from main_controller (col1_out..col5_out) onto the physical 7x5 LED matrix, one column at a time. Snapshots all five columns at each frame start so a frame never mixes old and new data. Adds anti-ghosting blanking between columns and an optional blink mode for attack-phase feedback.

Parameters:
DWELL_CYCLES, 10000, clk cycles each column is lit (min 1)
BLANK_CYCLES, 50, clk cycles all outputs inactive between columns (0 = no blank state)
BLINK_FRAMES, 100, frames per blink half-period (min 1)
COL_ACTIVE_LOW, 1, 1: selected column driven 0, others 1
ROW_ACTIVE_LOW, 0, 1: lit row driven 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable; tie to onOff
blink_en  in  1  blink whole image when high
col1_in..col5_in  in  7 each  column images; bit i = row i
col_sel  out  5  column strobes; bit 0 = column 1
row_out  out  7  row drive for selected column
frame_tick  out  1  one-cycle pulse at end of each frame

Behaviour:
- Synchronous, active-high reset on the clk edge. Reset and idle values: state IDLE; col_idx 0; counters 0; snapshot 0; blink_phase 0; frame_tick 0; col_sel all inactive (5'b11111 when COL_ACTIVE_LOW=1); row_out all unlit.
- All outputs are registered. They take their value on the same edge that enters a state.
- IDLE: outputs inactive. If enable=1 -> LOAD.
- LOAD (1 cycle): capture col1_in..col5_in into snapshot; col_idx<=0 -> DWELL.
- DWELL: col_sel drives only bit col_idx active.
  - row_out = snapshot[col_idx] with ROW_ACTIVE_LOW polarity applied.
  - If blink_en=1 and blink_phase=1, row_out is forced unlit; col_sel still scans.
  - Stays exactly DWELL_CYCLES cycles. Then -> BLANK if BLANK_CYCLES>0, else directly to the end-of-column step.
- BLANK: all outputs inactive for exactly BLANK_CYCLES cycles.
- End of column:
  - col_idx<4: col_idx+1 -> DWELL.
  - col_idx==4: frame_tick=1 for one cycle, frame_cnt+1 -> LOAD.
- Blink timing: frame_cnt counts 0..BLINK_FRAMES-1 and wraps to 0. blink_phase toggles on each wrap. blink_phase keeps running while blink_en=0.
- Latency: enable sampled high at edge N -> LOAD after N -> first column lit after edge N+1.
- Frame period = 5*(DWELL_CYCLES+BLANK_CYCLES)+1 cycles.
- Input changes mid-frame have no effect until the next LOAD.
- enable=0 in any state -> IDLE on the next edge; outputs inactive that edge; no frame_tick. A later enable restarts at LOAD with column 1. frame_cnt and blink_phase are kept.
- reset has priority over enable and all state; reset mid-frame yields reset values on the next edge.
- Exactly one col_sel bit is active in DWELL; none in any other state, including at state boundaries.
- Counter widths are sized by $clog2 of the parameter values. No overflow is possible.

Decomposition:
- Shared package (matrix_pkg):
  - NUM_COLS=5, NUM_ROWS=7.
  - State enum IDLE/LOAD/DWELL/BLANK, 2-bit encoding.
  - Column-image typedef logic [6:0].
- One sub-module: scan_dwell_counter, a loadable down-counter with terminal-count flag. It is instantiated once and reloaded with DWELL_CYCLES or BLANK_CYCLES on each state entry.

Test Plan:
- Reset/idle: reset=1 for 3 cycles, enable=0 -> col_sel=5'b11111, row_out=0, frame_tick=0. Values hold after reset falls.
- Scan order (DWELL=4, BLANK=1; cols = 7'h01,02,04,08,10; enable=1):
  - col_sel sequence 11110,11101,11011,10111,01111; each held 4 cycles, with 1 cycle 11111 between.
  - row_out matches each column.
  - frame_tick pulses every 26 cycles.
- Snapshot: change col3_in from 7'h04 to 7'h7F while column 1 is lit -> column 3 still shows 7'h04 this frame and 7'h7F next frame.
- Mid-frame disable: drop enable during column 2 dwell -> next edge all inactive, no frame_tick.
  - Re-enable -> LOAD, then column 1 lit 2 edges later.
- Blink (BLINK_FRAMES=2, blink_en=1, all cols 7'h7F):
  - row_out 7'h7F for 2 frames, then 0 for 2 frames, repeating.
  - col_sel keeps scanning throughout.
- Reset mid-DWELL on column 4, plus BLANK_CYCLES=0 and ROW_ACTIVE_LOW=1 variant:
  - reset yields reset values on the next edge.
  - With no blank, columns are back-to-back with exactly one active bit each cycle.
  - Lit rows are driven 0.
